meta_intf_wrr_arbiter: RTL and testbench

- Weighted round-robin scheduler sharing one metaIntf output between N_INTERFACES metaIntf requesters.
- Each requester holds a burst grant of up to its weight in beats before the pointer rotates.
- Work-conserving: a grant is dropped as soon as the granted stream goes idle.
- Sits in front of shared per-card resources (e.g. one host-stream or descriptor queue) fed by several user streams.

---
 rtl/meta_arb_pkg.sv | 15 +
 rtl/meta_intf.sv | 20 ++
 rtl/meta_arb_rot_prio.sv | 41 ++++
 rtl/meta_intf_wrr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_meta_intf_wrr_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/meta_arb_pkg.sv
// ---------------------------------------------------------------------------
// meta_arb_pkg
// Shared definitions for the metaIntf weighted round-robin arbiter:
//   arb_state_t          - arbiter FSM states (idle / burst granted)
//   ARB_WEIGHT_BITS_DEF  - default width of a per-stream weight
//   ARB_STAT_BITS        - width of each per-stream accepted-beat counter
// ---------------------------------------------------------------------------
package meta_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int ARB_WEIGHT_BITS_DEF = 4;
    localparam int ARB_STAT_BITS       = 32;

endpackage

// File: rtl/meta_intf.sv
// ---------------------------------------------------------------------------
// metaIntf
// Minimal valid/ready stream carrying one STYPE payload per beat.
//   valid - source has a beat on data
//   ready - sink accepts the beat this cycle
//   data  - payload
// Modports: m (source side), s (sink side).
// ---------------------------------------------------------------------------
interface metaIntf #(
    parameter type STYPE = logic [63:0]
) ();

    logic valid;
    logic ready;
    STYPE data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);

endinterface

// File: rtl/meta_arb_rot_prio.sv
// ---------------------------------------------------------------------------
// meta_arb_rot_prio
// Combinational rotating priority encoder. Scans req starting at ptr and
// wrapping modulo N; the first asserted request wins.
//   req [N]   - request vector
//   ptr       - index with highest priority this cycle (must be < N)
//   any       - at least one request is asserted
//   sel       - index of the winning request (0 when any is low)
// ---------------------------------------------------------------------------
module meta_arb_rot_prio
    import meta_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] sel
);

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_w;
        logic             found;
        any   = |req;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(ptr) + k) % N;
            idx_w = PTR_W'(idx);
            if (!found && req[idx_w]) begin
                found = 1'b1;
                sel   = idx_w;
            end
        end
    end

endmodule

// File: rtl/meta_intf_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// meta_intf_wrr_arbiter
// Weighted round-robin scheduler sharing one registered metaIntf output
// between N_INTERFACES metaIntf requesters. A granted stream may send up to
// its weight in beats before the pointer rotates; the grant is dropped early
// as soon as the granted stream goes idle. Each grant costs one bubble cycle.
//
// Ports:
//   clk         - single clock
//   rst         - asynchronous, active-high reset
//   weight      - per-stream burst weight, WEIGHT_BITS each; 0 masks a stream
//   intf_in[]   - requester streams (sink side)
//   intf_out    - shared output stream, registered (source side)
//   grant_idx   - currently granted stream (debug)
//   stat_beats  - per-stream accepted-beat counters, 32 bits each
//
// Build option: define META_ARB_STATS_EN to implement the stat_beats
// counters; otherwise stat_beats is tied to zero.
// ---------------------------------------------------------------------------
module meta_intf_wrr_arbiter
    import meta_arb_pkg::*;
#(
    parameter int  N_STRM_AXI   = 4,
    parameter int  N_INTERFACES = N_STRM_AXI,
    parameter type STYPE        = logic [63:0],
    parameter int  WEIGHT_BITS  = ARB_WEIGHT_BITS_DEF,
    localparam int IDX_W        = $clog2(N_INTERFACES)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_INTERFACES*WEIGHT_BITS-1:0]    weight,
    metaIntf.s                                     intf_in [N_INTERFACES],
    metaIntf.m                                     intf_out,
    output logic [IDX_W-1:0]                       grant_idx,
    output logic [N_INTERFACES*ARB_STAT_BITS-1:0]  stat_beats
);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [WEIGHT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic [WEIGHT_BITS-1:0] w_lat_q, w_lat_d;
    logic                   out_valid_q, out_valid_d;
    STYPE                   out_data_q, out_data_d;

    logic [N_INTERFACES-1:0] in_valid;
    logic [N_INTERFACES-1:0] in_ready;
    logic [N_INTERFACES-1:0] eligible;
    STYPE                    in_data [N_INTERFACES];
    logic [WEIGHT_BITS-1:0]  w_arr   [N_INTERFACES];

    logic                    any_elig;
    logic [IDX_W-1:0]        pick;
    logic                    out_free;
    logic                    g_valid;
    STYPE                    g_data;
    logic                    hs;
    logic [IDX_W-1:0]        next_ptr;

    // Unpack the interface array into plain vectors so the granted stream
    // can be selected with a run-time index.
    for (genvar g = 0; g < N_INTERFACES; g++) begin : g_unpack
        assign in_valid[g]       = intf_in[g].valid;
        assign in_data[g]        = intf_in[g].data;
        assign intf_in[g].ready  = in_ready[g];
        assign w_arr[g]          = weight[g*WEIGHT_BITS +: WEIGHT_BITS];
        assign eligible[g]       = in_valid[g] & (w_arr[g] != '0);
    end

    meta_arb_rot_prio #(
        .N     (N_INTERFACES),
        .PTR_W (IDX_W)
    ) u_rot_prio (
        .req (eligible),
        .ptr (rr_ptr_q),
        .any (any_elig),
        .sel (pick)
    );

    // Datapath decode: the output register can take a new beat when it is
    // empty or being drained this cycle; only the granted input sees ready.
    always_comb begin
        out_free = !out_valid_q | intf_out.ready;
        g_valid  = in_valid[grant_q];
        g_data   = in_data[grant_q];
        hs       = (state_q == ARB_GRANT) & out_free & g_valid;
        next_ptr = (grant_q == IDX_W'(N_INTERFACES - 1)) ? '0 : grant_q + IDX_W'(1);
        in_ready = '0;
        if (state_q == ARB_GRANT && out_free) begin
            in_ready[grant_q] = 1'b1;
        end
    end

    // Arbiter FSM and output register next-state logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        w_lat_d     = w_lat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ARB_IDLE: begin
                if (any_elig) begin
                    grant_d    = pick;
                    w_lat_d    = w_arr[pick];
                    beat_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + WEIGHT_BITS'(1);
                    if ((beat_cnt_q + WEIGHT_BITS'(1)) == w_lat_q) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (out_free && !g_valid) begin
                    // Granted stream went idle: release the grant early.
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (hs) begin
            out_data_d  = g_data;
            out_valid_d = 1'b1;
        end else if (out_valid_q && intf_out.ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            w_lat_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            w_lat_q     <= w_lat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign intf_out.valid = out_valid_q;
    assign intf_out.data  = out_data_q;
    assign grant_idx      = grant_q;

`ifdef META_ARB_STATS_EN
    // One free-running, wrapping counter per stream, stepped on each beat
    // accepted from that stream.
    for (genvar g = 0; g < N_INTERFACES; g++) begin : g_stats
        logic [ARB_STAT_BITS-1:0] stat_q, stat_d;

        always_comb begin
            stat_d = stat_q;
            if (hs && (grant_q == IDX_W'(g))) begin
                stat_d = stat_q + ARB_STAT_BITS'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stat_q <= '0;
            end else begin
                stat_q <= stat_d;
            end
        end

        assign stat_beats[g*ARB_STAT_BITS +: ARB_STAT_BITS] = stat_q;
    end
`else
    assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_meta_intf_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_meta_intf_wrr_arbiter
// Directed bench for meta_intf_wrr_arbiter with four requesters. Each source
// emits stream-tagged incrementing data {stream[7:0], count[55:0]}; expected
// output is given per cycle as a hand-derived table of stream ids (-1 means
// the output register must be empty that cycle).
// ---------------------------------------------------------------------------
module tb_meta_intf_wrr_arbiter;

    localparam int N  = 4;
    localparam int WB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*WB-1:0]   weight;
    logic              out_ready;
    logic [N-1:0]      tb_valid;
    logic [63:0]       tb_data [N];
    logic [N-1:0]      tb_ready;
    logic              out_valid;
    logic [63:0]       out_data;
    logic [1:0]        grant_idx;
    logic [N*32-1:0]   stat_beats;

    int checks = 0;
    int errors = 0;

    bit         src_en     [N];
    int         src_remain [N];
    int         src_cnt    [N];
    int         exp_cnt    [N];
    int         exp_q[$];
    bit         rdy_q[$];
    logic [N-1:0] never_ready_mask;

    always #5 clk = ~clk;

    metaIntf #(.STYPE(logic [63:0])) in_if [N] ();
    metaIntf #(.STYPE(logic [63:0])) out_if ();

    for (genvar g = 0; g < N; g++) begin : g_wire
        assign in_if[g].valid = tb_valid[g];
        assign in_if[g].data  = tb_data[g];
        assign tb_ready[g]    = in_if[g].ready;
    end

    assign out_if.ready = out_ready;
    assign out_valid    = out_if.valid;
    assign out_data     = out_if.data;

    meta_intf_wrr_arbiter #(
        .N_STRM_AXI   (N),
        .N_INTERFACES (N),
        .STYPE        (logic [63:0]),
        .WEIGHT_BITS  (WB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .weight     (weight),
        .intf_in    (in_if),
        .intf_out   (out_if),
        .grant_idx  (grant_idx),
        .stat_beats (stat_beats)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input bit rdy);
        out_ready = rdy;
        for (int i = 0; i < N; i++) begin
            tb_valid[i] = src_en[i] && (src_remain[i] != 0);
            tb_data[i]  = {8'(i), 56'(src_cnt[i])};
        end
    endtask

    task automatic checkOutput(input string tag, input int exp_s, input bit rdy);
        logic [63:0] e;
        if (exp_s < 0) begin
            checkVal({tag, " valid"}, {63'd0, out_valid}, 64'd0);
        end else begin
            checkVal({tag, " valid"}, {63'd0, out_valid}, 64'd1);
            e = {8'(exp_s), 56'(exp_cnt[exp_s])};
            checkVal({tag, " data"}, out_data, e);
            if (rdy) exp_cnt[exp_s]++;
        end
        if (!rdy) checkVal({tag, " stalled ready"}, {60'd0, tb_ready}, 64'd0);
        if (never_ready_mask != '0)
            checkVal({tag, " masked ready"}, {60'd0, tb_ready & never_ready_mask}, 64'd0);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, then advance
    // the sources that handshook at the following edge.
    task automatic tick(input string tag, input int exp_s, input bit rdy);
        bit hs [N];
        applyStimulus(rdy);
        @(negedge clk);
        checkOutput(tag, exp_s, rdy);
        for (int i = 0; i < N; i++) hs[i] = tb_valid[i] & tb_ready[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                src_cnt[i]++;
                if (src_remain[i] > 0) src_remain[i]--;
            end
        end
    endtask

    task automatic runTable(input string tag);
        for (int c = 0; c < exp_q.size(); c++) tick(tag, exp_q[c], rdy_q[c]);
    endtask

    task automatic allReady();
        rdy_q = {};
        for (int c = 0; c < exp_q.size(); c++) rdy_q.push_back(1'b1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0;
            exp_cnt[i] = 0;
        end
        applyStimulus(1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset valid", {63'd0, out_valid}, 64'd0);
        checkVal("reset data", out_data, 64'd0);
        checkVal("reset grant_idx", {62'd0, grant_idx}, 64'd0);
        checkVal("reset stat_beats", {63'd0, |stat_beats}, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        out_ready        = 1'b1;
        never_ready_mask = '0;
        weight           = {4'd4, 4'd3, 4'd2, 4'd1};
        src_en           = '{1'b1, 1'b1, 1'b1, 1'b1};
        src_remain       = '{-1, -1, -1, -1};
        src_cnt          = '{0, 0, 0, 0};
        exp_cnt          = '{0, 0, 0, 0};
        applyStimulus(1'b1);

        $display("[TB] weighted order, weights 1,2,3,4");
        doReset();
        exp_q = '{-1, -1, 0, -1, 1, 1, -1, 2, 2, 2, -1, 3, 3, 3, 3, -1,
                   0, -1, 1, 1, -1, 2, 2, 2, -1, 3, 3, 3, 3, -1};
        allReady();
        runTable("t1");
        checkVal("t1 beats s0", 64'(src_cnt[0]), 64'd3);
        checkVal("t1 beats s1", 64'(src_cnt[1]), 64'd4);
        checkVal("t1 beats s2", 64'(src_cnt[2]), 64'd6);
        checkVal("t1 beats s3", 64'(src_cnt[3]), 64'd8);
`ifdef META_ARB_STATS_EN
        checkVal("t1 stat s0", 64'(stat_beats[31:0]),   64'd3);
        checkVal("t1 stat s1", 64'(stat_beats[63:32]),  64'd4);
        checkVal("t1 stat s2", 64'(stat_beats[95:64]),  64'd6);
        checkVal("t1 stat s3", 64'(stat_beats[127:96]), 64'd8);
`endif

        $display("[TB] single stream 2, weight 3");
        src_en = '{1'b0, 1'b0, 1'b1, 1'b0};
        doReset();
        exp_q = '{-1, -1, 2, 2, 2, -1, 2, 2, 2, -1, 2, 2, 2, -1};
        allReady();
        runTable("t2");
        checkVal("t2 grant_idx", {62'd0, grant_idx}, 64'd2);

        $display("[TB] early drop of stream 1");
        weight     = {4'd4, 4'd3, 4'd4, 4'd1};
        src_en     = '{1'b0, 1'b1, 1'b1, 1'b0};
        src_remain = '{-1, 2, -1, -1};
        doReset();
        exp_q = '{-1, -1, 1, 1, -1, -1, 2, 2, 2, -1, 2, 2, 2};
        allReady();
        runTable("t3");
        checkVal("t3 grant_idx", {62'd0, grant_idx}, 64'd2);
        checkVal("t3 beats s1", 64'(src_cnt[1]), 64'd2);

        $display("[TB] output backpressure mid-burst");
        weight     = {4'd4, 4'd3, 4'd2, 4'd1};
        src_en     = '{1'b0, 1'b0, 1'b0, 1'b1};
        src_remain = '{-1, -1, -1, -1};
        doReset();
        exp_q = '{-1, -1, 3, 3, 3, 3, 3, 3, 3, 3, 3, -1, 3, 3};
        allReady();
        for (int c = 3; c <= 7; c++) rdy_q[c] = 1'b0;
        runTable("t4");

        $display("[TB] zero weight masks stream 0");
        weight           = {4'd0, 4'd0, 4'd2, 4'd0};
        src_en           = '{1'b1, 1'b1, 1'b0, 1'b0};
        never_ready_mask = 4'b0001;
        doReset();
        exp_q = '{-1, -1, 1, 1, -1, 1, 1, -1, 1, 1, -1};
        allReady();
        runTable("t5a");

        $display("[TB] all weights zero");
        weight           = '0;
        src_en           = '{1'b1, 1'b1, 1'b1, 1'b1};
        never_ready_mask = 4'b1111;
        doReset();
        exp_q = {};
        for (int c = 0; c < 100; c++) exp_q.push_back(-1);
        allReady();
        runTable("t5b");
        never_ready_mask = '0;

        $display("[TB] asynchronous reset during a burst");
        weight = {4'd4, 4'd3, 4'd2, 4'd1};
        doReset();
        exp_q = '{-1, -1, 0, -1, 1};
        allReady();
        runTable("t6a");
        checkVal("t6 pre-reset valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkVal("t6 async reset valid", {63'd0, out_valid}, 64'd0);
        doReset();
        exp_q = '{-1, -1, 0, -1, 1, 1, -1, 2};
        allReady();
        runTable("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
